// File: rtl/instr_lb_pkg.sv
// Shared types and constants for the single-line instruction buffer.
// Also holds the word-select helper used to pick a 32-bit word out of a line.
package instr_lb_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 4;
    localparam int WORD_BITS      = 32;
    localparam int LINE_BITS      = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2
    } lb_state_e;

    // Word n of a line occupies bits [32n+31:32n].
    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           idx
    );
        logic [WORD_BITS-1:0] w;
        case (idx)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_line_buffer.sv
// One-line (16-byte) instruction buffer between a 32-bit fetch port and a
// 128-bit ram instruction port; hits are served from the line, misses refill it.
module instr_line_buffer
    import instr_lb_pkg::*;
#(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  flush_i,
    output logic                  ram_req_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic                  ram_gnt_i,
    input  logic                  ram_rvalid_i,
    input  logic [127:0]          ram_rdata_i
);

    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;

    lb_state_e              state;
    lb_state_e              state_next;
    logic                   line_valid;
    logic [TAG_W-1:0]       tag;
    logic [TAG_W-1:0]       fill_tag;
    logic [LINE_BITS-1:0]   line;
    logic                   drop;
    logic                   rvalid;
    logic [31:0]            rdata;

    logic [TAG_W-1:0]       req_tag;
    logic                   hit;
    logic                   gnt;
    logic                   miss_start;
    logic                   fill_done;
    logic                   ram_req;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic                   unused_addr_bits;

    assign req_tag          = instr_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_addr_bits = ^instr_addr_i[1:0];

    // A flush cycle never hits, so the same request falls through to a refill.
    assign hit = instr_req_i & line_valid & (req_tag == tag)
               & (state == IDLE) & ~flush_i;

    // Next-state and combinational handshake outputs.
    always_comb begin
        state_next = state;
        gnt        = 1'b0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        ram_req    = 1'b0;
        ram_addr   = {ADDR_WIDTH{1'b0}};
        case (state)
            IDLE: begin
                if (hit) begin
                    gnt = 1'b1;
                end else if (instr_req_i) begin
                    miss_start = 1'b1;
                    ram_req    = 1'b1;
                    ram_addr   = {req_tag, 4'b0000};
                    if (ram_gnt_i) begin
                        state_next = FILL_WAIT;
                    end else begin
                        state_next = FILL_REQ;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            FILL_REQ: begin
                ram_req  = 1'b1;
                ram_addr = {fill_tag, 4'b0000};
                if (ram_gnt_i) begin
                    state_next = FILL_WAIT;
                end else begin
                    state_next = FILL_REQ;
                end
            end
            FILL_WAIT: begin
                if (ram_rvalid_i) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = FILL_WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign instr_gnt_o    = gnt;
    assign ram_req_o      = ram_req;
    assign ram_addr_o     = ram_addr;
    assign instr_rvalid_o = rvalid;
    assign instr_rdata_o  = rdata;

    // State register; reset abandons any fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the line address of the request that missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_tag <= {TAG_W{1'b0}};
        end else if (miss_start) begin
            fill_tag <= req_tag;
        end else begin
            fill_tag <= fill_tag;
        end
    end

    // Line data and tag are written on every completed fill, dropped or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= {LINE_BITS{1'b0}};
            tag  <= {TAG_W{1'b0}};
        end else if (fill_done) begin
            line <= ram_rdata_i;
            tag  <= fill_tag;
        end else begin
            line <= line;
            tag  <= tag;
        end
    end

    // Validity: a flush, or a flush seen at any point during the fill, wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= 1'b0;
        end else if (fill_done) begin
            line_valid <= ~(drop | flush_i);
        end else if (flush_i) begin
            line_valid <= 1'b0;
        end else begin
            line_valid <= line_valid;
        end
    end

    // Remember a flush that arrived while a fill was outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (fill_done || (state == IDLE)) begin
            drop <= 1'b0;
        end else if (flush_i) begin
            drop <= 1'b1;
        end else begin
            drop <= drop;
        end
    end

    // Core response, one cycle after each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0000_0000;
        end else if (gnt) begin
            rvalid <= 1'b1;
            rdata  <= line_word(line, instr_addr_i[3:2]);
        end else begin
            rvalid <= 1'b0;
            rdata  <= rdata;
        end
    end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Self-checking bench for instr_line_buffer: directed scenarios then random
// traffic, checked against a transaction-level model of the line buffer.
module tb_instr_line_buffer;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          flush_i;
    logic          ram_req_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_gnt_i;
    logic          ram_rvalid_i;
    logic [127:0]  ram_rdata_i;

    instr_line_buffer #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .flush_i        (flush_i),
        .ram_req_o      (ram_req_o),
        .ram_addr_o     (ram_addr_o),
        .ram_gnt_i      (ram_gnt_i),
        .ram_rvalid_i   (ram_rvalid_i),
        .ram_rdata_i    (ram_rdata_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // stimulus controls
    logic          core_req   = 1'b0;
    logic [AW-1:0] core_addr  = '0;
    logic          flush_v    = 1'b0;
    logic          ram_gnt_en = 1'b1;
    int            ram_lat    = 1;
    logic          stray_rv   = 1'b0;

    // ram responder state
    logic          ram_busy = 1'b0;
    int            ram_cnt  = 0;
    logic [17:0]   ram_line = '0;

    // reference model: what the buffer holds and what is owed to the core
    logic          m_valid  = 1'b0;
    logic [17:0]   m_tag    = '0;
    logic          m_busy   = 1'b0;
    logic          m_acc    = 1'b0;
    logic          m_drop   = 1'b0;
    logic [17:0]   m_fill   = '0;
    logic          m_rv     = 1'b0;
    logic [31:0]   m_rdata  = '0;

    logic          last_gnt = 1'b0;
    int            fills    = 0;
    int            rv_count = 0;
    logic [31:0]   last_rdata = '0;

    function automatic logic [127:0] line_data(input logic [17:0] t);
        logic [127:0] d;
        if (t == 18'h00010) begin
            d = {32'h4, 32'h3, 32'h2, 32'h1};
        end else begin
            for (int n = 0; n < 4; n++) d[32*n +: 32] = {t, n[1:0], 12'hA5C};
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic          m_hit;
        logic          exp_rr;
        logic [AW-1:0] exp_ra;
        logic          delivered;
        @(negedge clk);
        if (ram_busy && ram_cnt > 0) ram_cnt--;
        instr_req_i  = core_req;
        instr_addr_i = core_addr;
        flush_i      = flush_v;
        ram_gnt_i    = ram_gnt_en;
        delivered    = ram_busy && (ram_cnt == 0);
        ram_rvalid_i = delivered || stray_rv;
        ram_rdata_i  = delivered ? line_data(ram_line)
                                 : {$urandom, $urandom, $urandom, $urandom};
        #1;
        m_hit  = core_req && !m_busy && m_valid && (m_tag == core_addr[21:4]) && !flush_v;
        exp_rr = (core_req && !m_busy && !m_hit) || (m_busy && !m_acc);
        exp_ra = {(m_busy ? m_fill : core_addr[21:4]), 4'b0000};
        chk("gnt", instr_gnt_o, m_hit);
        chk("ram_req", ram_req_o, exp_rr);
        if (exp_rr) chk("ram_addr", ram_addr_o, exp_ra);
        chk("rvalid", instr_rvalid_o, m_rv);
        if (m_rv) chk("rdata", instr_rdata_o, m_rdata);
        if (instr_rvalid_o) begin
            rv_count++;
            last_rdata = instr_rdata_o;
        end
        if (ram_req_o && ram_gnt_i) fills++;
        // ram responder
        if (delivered) ram_busy = 1'b0;
        if (exp_rr && ram_gnt_en) begin
            ram_busy = 1'b1;
            ram_cnt  = ram_lat;
            ram_line = exp_ra[21:4];
        end
        // model update
        m_rv    = m_hit;
        m_rdata = line_data(core_addr[21:4])[32*core_addr[3:2] +: 32];
        if (flush_v) m_valid = 1'b0;
        if (m_busy && flush_v) m_drop = 1'b1;
        if (m_busy && m_acc && delivered) begin
            m_valid = !(m_drop || flush_v);
            m_tag   = m_fill;
            m_busy  = 1'b0;
            m_drop  = 1'b0;
        end else if (m_busy && !m_acc && ram_gnt_en) begin
            m_acc = 1'b1;
        end else if (!m_busy && core_req && !m_hit) begin
            m_busy = 1'b1;
            m_acc  = ram_gnt_en;
            m_fill = core_addr[21:4];
        end
        last_gnt = m_hit;
    endtask

    task automatic fetch(input logic [AW-1:0] a, output int cyc);
        core_req  = 1'b1;
        core_addr = a;
        cyc       = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_gnt) begin
                cyc = i;
                break;
            end
        end
        chk("fetch_gnt", last_gnt, 1'b1);
    endtask

    task automatic drain();
        core_req = 1'b0;
        flush_v  = 1'b0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        core_req = 1'b0; flush_v = 1'b0; stray_rv = 1'b0;
        instr_req_i = 1'b0; flush_i = 1'b0; ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0;
        #1;
        chk("rst_gnt", instr_gnt_o, 1'b0);
        chk("rst_rvalid", instr_rvalid_o, 1'b0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_ram_req", ram_req_o, 1'b0);
        chk("rst_ram_addr", ram_addr_o, 22'h0);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_busy = 1'b0; m_acc = 1'b0; m_drop = 1'b0; m_rv = 1'b0;
        ram_busy = 1'b0; last_gnt = 1'b0;
    endtask

    initial begin
        int cyc;
        int f0;
        int r0;
        rst = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = '0; flush_i = 1'b0;
        ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0; ram_rdata_i = '0;
        do_reset();

        // 1: cold miss with zero-wait ram
        ram_gnt_en = 1'b1; ram_lat = 1;
        fetch(22'h100, cyc);
        chk("t1_gnt_cycle", cyc, 2);
        // 2: sequential hits in the same line
        fetch(22'h104, cyc);
        chk("t1_rdata", last_rdata, 32'h1);
        chk("t2_gnt0", cyc, 0);
        f0 = fills;
        fetch(22'h108, cyc);
        chk("t2_gnt1", cyc, 0);
        fetch(22'h10C, cyc);
        chk("t2_gnt2", cyc, 0);
        drain();
        chk("t2_last_rdata", last_rdata, 32'h4);
        chk("t2_no_fill", fills, f0);

        // 3: a different line evicts the first
        f0 = fills;
        fetch(22'h110, cyc);
        fetch(22'h100, cyc);
        drain();
        chk("t3_fills", fills, f0 + 2);

        // 4: flush while the fill is outstanding forces a refetch
        ram_lat = 3; f0 = fills; r0 = rv_count;
        core_req = 1'b1; core_addr = 22'h204;
        step();
        flush_v = 1'b1;
        step();
        flush_v = 1'b0;
        fetch(22'h204, cyc);
        drain();
        chk("t4_fills", fills, f0 + 2);
        chk("t4_rvalids", rv_count, r0 + 1);
        chk("t4_rdata", last_rdata, line_data(18'h20)[63:32]);

        // 5: ram stalls the request for three cycles
        ram_lat = 1; ram_gnt_en = 1'b0; f0 = fills;
        core_req = 1'b1; core_addr = 22'h408;
        for (int i = 0; i < 3; i++) step();
        ram_gnt_en = 1'b1;
        fetch(22'h408, cyc);
        drain();
        chk("t5_fills", fills, f0 + 1);

        // 6: reset mid-fill, stray ram rvalid afterwards
        ram_lat = 3;
        core_req = 1'b1; core_addr = 22'h300;
        step();
        step();
        do_reset();
        stray_rv = 1'b1;
        step();
        stray_rv = 1'b0;
        f0 = fills;
        fetch(22'h300, cyc);
        drain();
        chk("t6_refill", fills, f0 + 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!core_req || last_gnt) begin
                core_req = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 4))
                    0: core_addr = 22'h100;
                    1: core_addr = 22'h110;
                    2: core_addr = 22'h200;
                    3: core_addr = 22'h120;
                    default: core_addr = 22'($urandom);
                endcase
                core_addr[3:0] = 4'($urandom);
                if ($urandom_range(0, 2) != 0) core_addr[21:4] = m_tag;
            end
            flush_v    = ($urandom_range(0, 24) == 0);
            ram_gnt_en = ($urandom_range(0, 9) < 7);
            ram_lat    = $urandom_range(1, 3);
            step();
        end
        ram_gnt_en = 1'b1;
        drain();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
